// File: rtl/node_tx.sv
// -----------------------------------------------------------------------------
// node_tx -- outbound half of a NoC node.
//
// Buffers 32-bit packets {sourceID[31:28], destID[27:24], data[23:0]} in a
// circular queue and sends each one to a router input port as four 8-bit
// beats. The router's free signal acts as a per-packet credit. It is sampled
// only in IDLE, so a burst that has started always completes all four beats.
//
// Byte order on the link: b0 = {sourceID, destID}, b1 = data[23:16],
// b2 = data[15:8], b3 = data[7:0].
//
// Optional feature (compile-time macro NODE_TX_SRCID_STAMP_EN):
//   defined     -> b0 = {NODEID[3:0], destID}. The packet's sourceID is ignored.
//   not defined -> b0 = {sourceID, destID}, passed through unmodified.
//
// Parameters:
//   NODEID  this node's ID (0..5). Used only by the stamp feature.
//   QDEPTH  queue depth in packets. Must be a power of 2 and at least 2.
//
// Ports:
//   clk               in   clock; all state changes on the rising edge
//   rst_b             in   synchronous, active-high reset
//   pkt_in[31:0]      in   packet to enqueue
//   pkt_in_avail      in   enqueue request; ignored while cQ_full is high
//   cQ_full           out  queue holds QDEPTH packets (combinational from count)
//   free_inbound      in   router port can accept a whole packet
//   put_outbound      out  beat valid (registered)
//   payload_outbound  out  beat data (registered)
// -----------------------------------------------------------------------------
module node_tx #(
  parameter int NODEID = 0,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [31:0] pkt_in,
  input  logic        pkt_in_avail,
  output logic        cQ_full,
  input  logic        free_inbound,
  output logic        put_outbound,
  output logic [7:0]  payload_outbound
);

  localparam int AW = $clog2(QDEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [31:0]   mem [QDEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW:0]   count;
  state_t        state;
  logic [1:0]    beat;
  logic [23:0]   shreg;     // bytes b1..b3 still to send, next one in [23:16]

  logic          push;
  logic          pop;
  logic [31:0]   head;
  logic [7:0]    head_b0;

  // Fullness is decided from the current count alone. A pop in the same cycle
  // does not make room for a new packet.
  assign cQ_full = (count == (AW+1)'(QDEPTH));
  assign push    = pkt_in_avail && !cQ_full;
  // A packet written at this edge is not visible here, because count still
  // reflects the old contents. That gives "head read before write".
  assign pop     = (state == IDLE) && (count != '0) && free_inbound;
  assign head    = mem[rd];

`ifdef NODE_TX_SRCID_STAMP_EN
  assign head_b0 = {4'(NODEID), head[27:24]};
`else
  assign head_b0 = head[31:24];
`endif

  // NOTE: the packet storage has no reset. The rd, wr and count registers
  // decide which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= pkt_in;
  end

  // NOTE: all state is updated with non-blocking assignments. Every right-hand
  // side therefore sees the pre-edge values, which matches the hardware.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      rd               <= '0;
      wr               <= '0;
      count            <= '0;
      state            <= IDLE;
      beat             <= '0;
      shreg            <= '0;
      put_outbound     <= 1'b0;
      payload_outbound <= 8'h00;
    end else begin
      // QDEPTH is a power of 2, so the pointers wrap on natural overflow.
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;  // idle, or enqueue and pop together: count unchanged
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            state            <= SEND;
            beat             <= 2'd0;
            put_outbound     <= 1'b1;
            payload_outbound <= head_b0;
            shreg            <= head[23:0];
          end else begin
            put_outbound     <= 1'b0;
          end
        end
        SEND: begin
          // free_inbound is deliberately ignored here: a burst never stalls.
          if (beat == 2'd3) begin
            state            <= IDLE;
            put_outbound     <= 1'b0;
          end else begin
            beat             <= beat + 1'b1;
            put_outbound     <= 1'b1;
            payload_outbound <= shreg[23:16];
            shreg            <= {shreg[15:0], 8'h00};
          end
        end
        default: begin
          state        <= IDLE;
          put_outbound <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_tx.sv
// -----------------------------------------------------------------------------
// tb_node_tx -- scoreboard bench for node_tx (NODEID=2, QDEPTH=4).
//
// The stimulus pushes the expected beats, plus the expected length of each
// burst, into queues. A monitor samples the link on the falling clock edge.
// It pops and compares one byte for every put cycle, and it compares the
// burst length when put falls.
// -----------------------------------------------------------------------------
module tb_node_tx;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [31:0] pkt_in = '0;
  logic        pkt_in_avail = 1'b0;
  logic        free_inbound = 1'b0;
  logic        cQ_full;
  logic        put_outbound;
  logic [7:0]  payload_outbound;

  node_tx #(.NODEID(2), .QDEPTH(4)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .pkt_in           (pkt_in),
    .pkt_in_avail     (pkt_in_avail),
    .cQ_full          (cQ_full),
    .free_inbound     (free_inbound),
    .put_outbound     (put_outbound),
    .payload_outbound (payload_outbound)
  );

  always #5 clk = ~clk;

`ifdef NODE_TX_SRCID_STAMP_EN
  localparam logic [7:0] STAMP_B0 = 8'h25;
`else
  localparam logic [7:0] STAMP_B0 = 8'h75;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         len_q[$];
  int         run = 0;

  function automatic logic [7:0] exp_b0(input logic [31:0] p);
`ifdef NODE_TX_SRCID_STAMP_EN
    return {4'd2, p[27:24]};
`else
    return p[31:24];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Queue the first n beats of packet p, and a burst of length n.
  task automatic expect_pkt(input logic [31:0] p, input int n);
    logic [7:0] b [4];
    b[0] = exp_b0(p);
    b[1] = p[23:16];
    b[2] = p[15:8];
    b[3] = p[7:0];
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
    len_q.push_back(n);
  endtask

  // Monitor: compares beats and burst lengths against the scoreboard queues.
  always @(negedge clk) begin
    if (put_outbound === 1'b1) begin
      run++;
      check("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("beat_data", payload_outbound, exp_q.pop_front());
    end else if (run != 0) begin
      check("burst_expected", len_q.size() != 0, 1'b1);
      if (len_q.size() != 0) check("burst_len", run, len_q.pop_front());
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] p);
    pkt_in       = p;
    pkt_in_avail = 1'b1;
    tick();
    pkt_in_avail = 1'b0;
  endtask

  task automatic wait_put(input string name);
    int i;
    i = 0;
    while (put_outbound !== 1'b1 && i < 50) begin
      tick();
      i++;
    end
    check(name, put_outbound, 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || len_q.size() != 0 ||
                                put_outbound === 1'b1); i++) tick();
    check(name, exp_q.size() + len_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pk [5];
    logic [31:0] p;

    // Reset state
    rst_b = 1'b1;
    tick();
    tick();
    rst_b = 1'b0;
    check("reset_put", put_outbound, 1'b0);
    check("reset_payload", payload_outbound, 8'h00);
    check("reset_full", cQ_full, 1'b0);

    // Single packet: latency and byte order
    free_inbound = 1'b1;
    expect_pkt(32'h13ABCDEF, 4);
    send(32'h13ABCDEF);                 // now in cycle T+1
    check("lat_t1_put", put_outbound, 1'b0);
    tick();
    check("lat_t2_put", put_outbound, 1'b1);
    check("lat_t2_b0", payload_outbound, 8'h13);
    tick();
    tick();
    tick();
    check("lat_t5_put", put_outbound, 1'b1);
    check("lat_t5_b3", payload_outbound, 8'hEF);
    tick();
    check("lat_t6_put", put_outbound, 1'b0);
    drain("single_drain");

    // Fill to full with free low; the fifth packet is dropped
    free_inbound = 1'b0;
    pk[0] = 32'h01112233; pk[1] = 32'h12445566; pk[2] = 32'h23778899;
    pk[3] = 32'h34AABBCC; pk[4] = 32'h45DDEEFF;
    for (int i = 0; i < 4; i++) begin
      expect_pkt(pk[i], 4);
      send(pk[i]);
      check("fill_full", cQ_full, i == 3);
    end
    send(pk[4]);
    check("full_held", cQ_full, 1'b1);
    free_inbound = 1'b1;
    tick();
    check("full_after_pop", cQ_full, 1'b0);
    drain("full_drain");

    // free drops after beat 0: the burst completes and the next packet waits
    free_inbound = 1'b0;
    expect_pkt(32'h56102030, 4);
    send(32'h56102030);
    expect_pkt(32'h67405060, 4);
    send(32'h67405060);
    free_inbound = 1'b1;
    wait_put("credit_start");
    free_inbound = 1'b0;
    repeat (10) tick();
    check("credit_hold_put", put_outbound, 1'b0);
    check("credit_pending", exp_q.size(), 4);
    free_inbound = 1'b1;
    drain("credit_drain");

    // Reset during beat 2 aborts the burst and flushes the queued packet
    expect_pkt(32'h78CAFE01, 3);
    send(32'h78CAFE01);
    send(32'h89BEEF02);                 // queued behind; lost at reset
    wait_put("rst_beat0");
    tick();
    tick();
    check("rst_beat2", payload_outbound, 8'hFE);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("rst_put", put_outbound, 1'b0);
    check("rst_full", cQ_full, 1'b0);
    repeat (6) tick();
    check("rst_quiet", put_outbound, 1'b0);
    drain("rst_drain");

    // Enqueue and pop in the same cycle with count==1
    free_inbound = 1'b0;
    expect_pkt(32'h9A111111, 4);
    send(32'h9A111111);
    free_inbound = 1'b1;
    expect_pkt(32'hAB222222, 4);
    send(32'hAB222222);                 // pop of the first packet on this edge
    check("sim_b0", payload_outbound, exp_b0(32'h9A111111));
    check("sim_full", cQ_full, 1'b0);
    repeat (4) tick();
    check("sim_gap", put_outbound, 1'b0);
    tick();
    check("sim_next_put", put_outbound, 1'b1);
    check("sim_next_b0", payload_outbound, exp_b0(32'hAB222222));
    drain("sim_drain");

    // Nine packets back to back exercise pointer wrap
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 50 && cQ_full === 1'b1; k++) tick();
      check("wrap_room", cQ_full, 1'b0);
      p = {4'hC, 4'(i), 8'(i * 17), 16'hBEEF ^ 16'(i)};
      expect_pkt(p, 4);
      send(p);
    end
    drain("wrap_drain");

    // Source-ID stamp (NODEID = 2)
    expect_pkt(32'h75123456, 4);
    send(32'h75123456);
    tick();
    check("stamp_b0", payload_outbound, STAMP_B0);
    drain("stamp_drain");

    check("sb_empty", exp_q.size() + len_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
